div_unit: RTL and testbench

Parametrised multi-cycle integer divider for the EX stage. It computes quotient and remainder for signed (DIV) and unsigned (DIVU) operations, which the EX stage writes to HI/LO. A radix-2 restoring datapath runs one iteration per cycle. While an operation is in flight the block raises a stall request so the pipeline freezes around EX.

---
 rtl/div_unit.sv | 140 ++++++++++++++
 tb/tb_div_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle radix-2 restoring divider for the EX stage (DIV/DIVU)
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             stall_req
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvsr;
  logic [CNT_W-1:0] cnt;
  logic             q_neg;
  logic             r_neg;

  logic             accept;
  logic             zero_div;
  logic             last;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH-1:0] abs_dividend;
  logic [WIDTH-1:0] abs_divisor;

  // The partial remainder is always below the divisor, so only WIDTH bits are
  // stored; the WIDTH+1-bit shifted value carries the bit shifted out of rem.
  always_comb begin
    rem_shift = {rem, quo[WIDTH-1]};
    trial     = rem_shift - {1'b0, dvsr};
    if (trial[WIDTH]) begin
      rem_next = rem_shift[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end else begin
      rem_next = trial[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end
    quo_fix = q_neg ? -quo_next : quo_next;
    rem_fix = r_neg ? -rem_next : rem_next;
  end

  always_comb begin
    abs_dividend = (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
    abs_divisor  = (signed_op && divisor[WIDTH-1])  ? -divisor  : divisor;
    accept       = (state == IDLE) && start && !cancel;
    zero_div     = (divisor == '0);
    last         = (cnt == CNT_W'(WIDTH - 1));
  end

  always_comb begin
    state_n   = state;
    busy      = 1'b0;
    done      = 1'b0;
    stall_req = 1'b0;
    case (state)
      IDLE: begin
        stall_req = start && !cancel;
        if (accept) state_n = zero_div ? DONE : BUSY;
      end
      BUSY: begin
        busy      = 1'b1;
        stall_req = 1'b1;
        if (cancel)    state_n = IDLE;
        else if (last) state_n = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        done    = !cancel;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rem         <= '0;
      quo         <= '0;
      dvsr        <= '0;
      cnt         <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (accept && zero_div) begin
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
          end else if (accept) begin
            rem   <= '0;
            quo   <= abs_dividend;
            dvsr  <= abs_divisor;
            cnt   <= '0;
            q_neg <= signed_op && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_neg <= signed_op && dividend[WIDTH-1];
          end
        end
        BUSY: begin
          if (!cancel) begin
            rem <= rem_next;
            quo <= quo_next;
            cnt <= cnt + 1'b1;
            if (last) begin
              quotient    <= quo_fix;
              remainder   <= rem_fix;
              div_by_zero <= 1'b0;
            end
          end else begin
            cnt <= '0;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed and table-driven bench for div_unit at WIDTH=32 and WIDTH=8
module tb_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, signed_op, cancel;
  logic [31:0] dividend, divisor, quotient, remainder;
  logic        busy, done, div_by_zero, stall_req;

  logic        start8, signed8, cancel8;
  logic [7:0]  dividend8, divisor8, quotient8, remainder8;
  logic        busy8, done8, dz8, stall8;

  int nchk = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  div_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start), .signed_op(signed_op),
    .dividend(dividend), .divisor(divisor), .cancel(cancel), .busy(busy),
    .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .stall_req(stall_req)
  );

  div_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .signed_op(signed8),
    .dividend(dividend8), .divisor(divisor8), .cancel(cancel8), .busy(busy8),
    .done(done8), .quotient(quotient8), .remainder(remainder8),
    .div_by_zero(dz8), .stall_req(stall8)
  );

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } vec_t;

  vec_t tv[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Issues one request and waits for done; counts stall_req cycles that disagree.
  task automatic run32(input logic s, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int stall_bad);
    @(negedge clk);
    start = 1'b1; signed_op = s; dividend = a; divisor = b;
    lat = 0; stall_bad = 0;
    #1;
    if (!stall_req) stall_bad++;
    while (lat < 100) begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      #1;
      if (done) begin
        if (stall_req) stall_bad++;
        break;
      end
      if (!stall_req) stall_bad++;
    end
  endtask

  task automatic run8(input logic s, input logic [7:0] a, input logic [7:0] b, output int lat);
    @(negedge clk);
    start8 = 1'b1; signed8 = s; dividend8 = a; divisor8 = b;
    lat = 0;
    while (lat < 100) begin
      @(negedge clk);
      start8 = 1'b0;
      lat++;
      #1;
      if (done8) break;
    end
  endtask

  task automatic model8(input logic s, input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] q, output logic [7:0] r, output logic dz);
    int ia, ib, iq, ir;
    if (b == 8'd0) begin
      q = 8'hFF; r = a; dz = 1'b1;
    end else begin
      ia = s ? int'($signed(a)) : int'(a);
      ib = s ? int'($signed(b)) : int'(b);
      iq = ia / ib;
      ir = ia % ib;
      q  = iq[7:0];
      r  = ir[7:0];
      dz = 1'b0;
    end
  endtask

  initial begin
    int lat, sbad, seen;
    logic [7:0] a8, b8, eq8, er8;
    logic ed8, s8;

    tv[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    tv[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0};
    tv[2]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0};
    tv[3]  = '{1'b0, 32'hFFFFFFF9,   32'd2,          32'h7FFFFFFC,   32'd1,          1'b0};
    tv[4]  = '{1'b1, 32'h12345678,   32'd0,          32'hFFFFFFFF,   32'h12345678,   1'b1};
    tv[5]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0};
    tv[6]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0};
    tv[7]  = '{1'b0, 32'd5,          32'd7,          32'd0,          32'd5,          1'b0};
    tv[8]  = '{1'b1, 32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0};
    tv[9]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   1'b0};
    tv[10] = '{1'b1, 32'd0,          32'hFFFFFFFF,   32'd0,          32'd0,          1'b0};
    tv[11] = '{1'b0, 32'd0,          32'd0,          32'hFFFFFFFF,   32'd0,          1'b1};

    reset = 1'b1; start = 1'b0; signed_op = 1'b0; cancel = 1'b0;
    dividend = '0; divisor = '0;
    start8 = 1'b0; signed8 = 1'b0; cancel8 = 1'b0; dividend8 = '0; divisor8 = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {busy, done, div_by_zero, stall_req, quotient, remainder}, '0);
    chk("reset_outputs8", {busy8, done8, dz8, stall8, quotient8, remainder8}, '0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run32(tv[i].s, tv[i].a, tv[i].b, lat, sbad);
      chk($sformatf("v%0d_quotient", i), quotient, tv[i].q);
      chk($sformatf("v%0d_remainder", i), remainder, tv[i].r);
      chk($sformatf("v%0d_div_by_zero", i), div_by_zero, tv[i].dz);
      chk($sformatf("v%0d_latency", i), lat, (tv[i].b == 0) ? 1 : 33);
      chk($sformatf("v%0d_stall_req", i), sbad, 0);
    end

    // cancel mid-operation: results from the last table entry must survive
    @(negedge clk);
    start = 1'b1; signed_op = 1'b0; dividend = 32'd1000; divisor = 32'd10;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    #1;
    chk("cancel_busy", {busy, done}, 2'b00);
    chk("cancel_hold", {div_by_zero, quotient, remainder}, {1'b1, 32'hFFFFFFFF, 32'd0});
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("cancel_no_done", seen, 0);
    run32(1'b0, 32'd9, 32'd3, lat, sbad);
    chk("after_cancel_result", {quotient, remainder}, {32'd3, 32'd0});
    chk("after_cancel_latency", lat, 33);

    // start and cancel together in IDLE
    @(negedge clk);
    start = 1'b1; cancel = 1'b1; dividend = 32'd9; divisor = 32'd3;
    #1;
    chk("start_cancel_stall", stall_req, 1'b0);
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    #1;
    chk("start_cancel_idle", busy, 1'b0);

    // cancel in DONE suppresses done but keeps results
    @(negedge clk);
    start = 1'b1; signed_op = 1'b1; dividend = 32'd5; divisor = 32'd0;
    @(negedge clk);
    start = 1'b0; cancel = 1'b1;
    #1;
    chk("done_cancel_pulse", done, 1'b0);
    chk("done_cancel_result", {div_by_zero, quotient, remainder}, {1'b1, 32'hFFFFFFFF, 32'd5});
    @(negedge clk);
    cancel = 1'b0;
    #1;
    chk("done_cancel_idle", busy, 1'b0);

    // reset mid-operation
    @(negedge clk);
    start = 1'b1; signed_op = 1'b0; dividend = 32'd1000; divisor = 32'd10;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("reset_mid_op", {busy, done, div_by_zero, stall_req, quotient, remainder}, '0);
    reset = 1'b0;
    run32(1'b0, 32'd15, 32'd4, lat, sbad);
    chk("after_reset_result", {quotient, remainder}, {32'd3, 32'd3});

    // WIDTH=8 instance
    run8(1'b0, 8'd200, 8'd13, lat);
    chk("w8_200_13", {quotient8, remainder8, dz8}, {8'd15, 8'd5, 1'b0});
    chk("w8_latency", lat, 9);
    run8(1'b1, 8'h80, 8'hFF, lat);
    chk("w8_overflow", {quotient8, remainder8, dz8}, {8'h80, 8'h00, 1'b0});
    for (int i = 0; i < 1000; i++) begin
      a8 = 8'($urandom);
      b8 = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
      s8 = 1'($urandom);
      model8(s8, a8, b8, eq8, er8, ed8);
      run8(s8, a8, b8, lat);
      chk($sformatf("w8_rand%0d_%s_%h_%h", i, s8 ? "s" : "u", a8, b8),
          {quotient8, remainder8, dz8, done8}, {eq8, er8, ed8, 1'b1});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
